// File: rtl/arcade_coin_sequencer.sv
// arcade_coin_sequencer: turns raw coin levels into clean, spaced, fixed-length coin pulses
//   clk           in   system clock
//   reset         in   synchronous, active-high
//   ce            in   timing tick for pulse/gap counters
//   controls_in   in   [8:0] {tilt, coin4..1, start4..1} level inputs
//   lockout       in   1 = discard new coin edges
//   controls_out  out  [8:0] {tilt, coin4..1, start4..1} to the core
//   busy          out  sequencer active or coins pending
//   coin_total    out  [15:0] accepted-coin count, built only with ARCADE_COIN_TOTAL_EN
module arcade_coin_sequencer #(
   parameter int PULSE_CYCLES = 8,
   parameter int GAP_CYCLES   = 8,
   parameter int QDEPTH_W     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic [8:0]  controls_in,
   input  logic        lockout,
   output logic [8:0]  controls_out,
   output logic        busy,
   output logic [15:0] coin_total
);
   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
   localparam logic [QDEPTH_W-1:0] PMAX = '1;
   state_t              r_state, w_state_nxt;
   logic [7:0]          r_cnt, w_cnt_nxt;
   logic [1:0]          r_sel, w_sel_nxt;
   logic [1:0]          r_rr, w_rr_nxt;
   logic [1:0]          w_gslot;
   logic                w_grant;
   logic [QDEPTH_W-1:0] r_pend [4];
   logic [3:0]          w_pending;
   logic [3:0]          r_coin_prev;
   logic [3:0]          w_rise;
   logic [3:0]          r_coin, w_coin_nxt;
   logic [3:0]          r_start;
   logic                r_tilt;

   assign w_rise       = controls_in[7:4] & ~r_coin_prev;
   assign controls_out = {r_tilt, r_coin, r_start};
   assign busy         = (r_state != IDLE) | (|w_pending);

   always_comb begin
      for (int i = 0; i < 4; i++) w_pending[i] = r_pend[i] != '0;
   end

   // Round-robin search starts one past the last granted slot; k=4 wraps to rr_ptr itself.
   always_comb begin
      w_grant = 1'b0;
      w_gslot = r_rr;
      for (int k = 1; k <= 4; k++)
         if (r_state == IDLE && !w_grant && w_pending[r_rr + 2'(k)]) begin
            w_grant = 1'b1;
            w_gslot = r_rr + 2'(k);
         end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sel_nxt   = r_sel;
      w_rr_nxt    = r_rr;
      case (r_state)
         IDLE:
            if (w_grant) begin
               w_state_nxt = PULSE;
               w_cnt_nxt   = '0;
               w_sel_nxt   = w_gslot;
               w_rr_nxt    = w_gslot;
            end
         PULSE:
            if (ce) begin
               w_state_nxt = (r_cnt == 8'(PULSE_CYCLES - 1)) ? GAP : PULSE;
               w_cnt_nxt   = (r_cnt == 8'(PULSE_CYCLES - 1)) ? 8'd0 : r_cnt + 8'd1;
            end
         GAP:
            if (ce) begin
               w_state_nxt = (r_cnt == 8'(GAP_CYCLES - 1)) ? IDLE : GAP;
               w_cnt_nxt   = (r_cnt == 8'(GAP_CYCLES - 1)) ? 8'd0 : r_cnt + 8'd1;
            end
         default: w_state_nxt = IDLE;
      endcase
      w_coin_nxt = (w_state_nxt == PULSE) ? 4'b0001 << w_sel_nxt : 4'b0000;
   end

   // coin_prev resets high so a coin held through reset is not seen as a new edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_sel       <= '0;
         r_rr        <= 2'd3;
         r_coin      <= '0;
         r_start     <= '0;
         r_tilt      <= 1'b0;
         r_coin_prev <= 4'hF;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sel       <= w_sel_nxt;
         r_rr        <= w_rr_nxt;
         r_coin      <= w_coin_nxt;
         r_start     <= controls_in[3:0];
         r_tilt      <= controls_in[8];
         r_coin_prev <= controls_in[7:4];
      end
   end

   // A simultaneous accept and grant leaves the count unchanged, even at saturation.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (reset)
            r_pend[i] <= '0;
         else if (w_rise[i] && !lockout && !(w_grant && w_gslot == 2'(i)) && r_pend[i] != PMAX)
            r_pend[i] <= r_pend[i] + 1'b1;
         else if (!(w_rise[i] && !lockout) && w_grant && w_gslot == 2'(i))
            r_pend[i] <= r_pend[i] - 1'b1;
   end

`ifdef ARCADE_COIN_TOTAL_EN
   logic [15:0] r_total;
   always_ff @(posedge clk) begin
      if (reset)
         r_total <= '0;
      else if (w_grant)
         r_total <= r_total + 16'd1;
   end
   assign coin_total = r_total;
`else
   assign coin_total = 16'h0000;
`endif
endmodule

// File: tb/tb_arcade_coin_sequencer.sv
// tb_arcade_coin_sequencer: directed and random checks against a countdown-based reference model
module tb_arcade_coin_sequencer;
   localparam int P    = 4;
   localparam int G    = 2;
   localparam int PMAX = 3;
   logic        clk = 1'b0;
   logic        reset, ce, lockout;
   logic [8:0]  controls_in, controls_out;
   logic        busy;
   logic [15:0] coin_total;
   int          total = 0;
   int          bad = 0;
   int          m_mode, m_rem, m_sel, m_rr, m_total;
   int          m_pend [4];
   logic [3:0]  m_prev, m_start;
   logic        m_tilt;
   int          pulses [4] = '{0, 0, 0, 0};
   logic [3:0]  last_coin = 4'h0;
   logic [8:0]  rci;

   arcade_coin_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .QDEPTH_W(2)) dut (
      .clk(clk), .reset(reset), .ce(ce), .controls_in(controls_in), .lockout(lockout),
      .controls_out(controls_out), .busy(busy), .coin_total(coin_total)
   );

   always #5 clk = ~clk;

   // mode 0 idle, 1 pulsing, 2 gap; m_rem counts remaining ce ticks in the phase
   task automatic model_edge(input logic [8:0] ci, input logic lk, input logic c, input logic r);
      bit gnt;
      int gs, s, inc, dec, nv;
      if (r) begin
         m_mode = 0; m_rem = 0; m_sel = 0; m_rr = 3; m_total = 0;
         for (int i = 0; i < 4; i++) m_pend[i] = 0;
         m_prev = 4'hF; m_start = 4'h0; m_tilt = 1'b0;
      end else begin
         gnt = 0; gs = 0;
         if (m_mode == 0)
            for (int k = 1; k <= 4; k++) begin
               s = (m_rr + k) % 4;
               if (!gnt && m_pend[s] > 0) begin gnt = 1; gs = s; end
            end
         if (gnt) begin
            m_mode = 1; m_rem = P; m_sel = gs; m_rr = gs;
         end else if (m_mode != 0 && c) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_mode = (m_mode == 1) ? 2 : 0;
               m_rem  = G;
            end
         end
         for (int i = 0; i < 4; i++) begin
            inc = (ci[4+i] && !m_prev[i] && !lk) ? 1 : 0;
            dec = (gnt && gs == i) ? 1 : 0;
            nv  = m_pend[i] + inc - dec;
            m_pend[i] = (nv > PMAX) ? PMAX : nv;
         end
         m_prev  = ci[7:4];
         m_start = ci[3:0];
         m_tilt  = ci[8];
         m_total = (m_total + (gnt ? 1 : 0)) % 65536;
      end
   endtask

   task automatic check();
      logic [8:0]  e;
      logic        eb;
      logic [15:0] et;
      e  = {m_tilt, (m_mode == 1) ? 4'(1 << m_sel) : 4'h0, m_start};
      eb = (m_mode != 0) || (m_pend[0] + m_pend[1] + m_pend[2] + m_pend[3] > 0);
`ifdef ARCADE_COIN_TOTAL_EN
      et = 16'(m_total);
`else
      et = 16'h0000;
`endif
      total++;
      assert (controls_out === e) else begin bad++; $error("FAIL controls_out got=%h exp=%h t=%0t", controls_out, e, $time); end
      total++;
      assert (busy === eb) else begin bad++; $error("FAIL busy got=%b exp=%b t=%0t", busy, eb, $time); end
      total++;
      assert (coin_total === et) else begin bad++; $error("FAIL coin_total got=%h exp=%h t=%0t", coin_total, et, $time); end
      total++;
      assert ($onehot0(controls_out[7:4]) === 1'b1) else begin bad++; $error("FAIL coin_onehot got=%b exp=onehot0 t=%0t", controls_out[7:4], $time); end
      for (int i = 0; i < 4; i++) if (controls_out[4+i] && !last_coin[i]) pulses[i]++;
      last_coin = controls_out[7:4];
   endtask

   task automatic step(input logic [8:0] ci, input logic lk = 1'b0, input logic c = 1'b1, input logic r = 1'b0);
      controls_in = ci; lockout = lk; ce = c; reset = r;
      @(posedge clk);
      model_edge(ci, lk, c, r);
      #1 check();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(9'h000);
   endtask

   task automatic cnt_chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin bad++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp); end
   endtask

   initial begin
      controls_in = '0; lockout = 1'b0; ce = 1'b1; reset = 1'b1;
      for (int i = 0; i < 3; i++) step(9'h000, 1'b0, 1'b1, 1'b1);
      idle(6);
      step(9'h010); idle(12);
      cnt_chk("coin1_single", pulses[0], 1);
      step(9'h050); idle(20);
      cnt_chk("coin1_pair", pulses[0], 2);
      cnt_chk("coin3_pair", pulses[2], 1);
      step(9'h010); step(9'h000);
      for (int i = 0; i < 5; i++) begin step(9'h020, 1'b0, 1'b0); step(9'h000, 1'b0, 1'b0); end
      idle(40);
      cnt_chk("coin2_rapid", pulses[1], 3);
      step(9'h080, 1'b1); step(9'h000, 1'b1); idle(6);
      cnt_chk("coin4_locked", pulses[3], 0);
      step(9'h080); step(9'h000);
      for (int i = 0; i < 10; i++) step(9'h000, 1'b1);
      idle(4);
      cnt_chk("coin4_inflight", pulses[3], 1);
      step(9'h010);
      for (int i = 0; i < 45; i++) step(9'h000, 1'b0, i % 3 == 2);
      idle(5);
      step(9'h010, 1'b0, 1'b1, 1'b1); step(9'h010, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(9'h010);
      idle(10);
      cnt_chk("coin1_held_reset", pulses[0], 4);
      step(9'h010); step(9'h000); step(9'h000); step(9'h000, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) step((i % 2) ? 9'h001 : 9'h000, 1'b1);
      idle(5);
      cnt_chk("coin1_mid_reset", pulses[0], 5);
      rci = 9'h000;
      for (int n = 0; n < 3000; n++) begin
         rci[3:0] = 4'($urandom);
         rci[8]   = ($urandom % 8) == 0;
         for (int i = 4; i < 8; i++) if ($urandom % 6 == 0) rci[i] = ~rci[i];
         step(rci, ($urandom % 12) == 0, ($urandom % 4) != 0, ($urandom % 400) == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
